// File: rtl/music_addr_gen.sv
// Song-address generator for the music box: drives the note-ROM address {song, step}.
// All outputs are registered. A tempo prescaler paces the steps, and loop and one-shot modes are both supported.
module music_addr_gen #(
  parameter int SONG_BITS = 1,
  parameter int STEP_BITS = 7,
  parameter int TEMPO_DIV = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [SONG_BITS-1:0]           sel,
  input  logic                           play,
  input  logic                           loop,
  input  logic [STEP_BITS-1:0]           song_len,
  output logic [SONG_BITS+STEP_BITS-1:0] addr,
  output logic                           playing,
  output logic                           done,
  output logic                           step_tick
);

  localparam int TDIV_W = (TEMPO_DIV > 1) ? $clog2(TEMPO_DIV) : 1;
  localparam logic [TDIV_W-1:0] TDIV_LAST = TDIV_W'(TEMPO_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  logic [SONG_BITS-1:0] r_song;
  logic [STEP_BITS-1:0] r_step;
  logic [TDIV_W-1:0]    r_tdiv;
  logic                 r_step_tick;
  logic                 r_playing;
  logic                 r_done;

  state_t               w_state_nxt;
  logic [SONG_BITS-1:0] w_song_nxt;
  logic [STEP_BITS-1:0] w_step_nxt;
  logic [TDIV_W-1:0]    w_tdiv_nxt;
  logic                 w_step_tick_nxt;
  logic                 w_playing_nxt;
  logic                 w_done_nxt;
  logic                 w_tick;
  logic                 w_sel_chg;
  logic                 w_more;

  assign w_tick    = (r_state == S_PLAY) && (r_tdiv == TDIV_LAST);
  assign w_sel_chg = (sel != r_song);
  // >= rather than == so a song_len lowered under the current step still ends the song
  assign w_more    = (r_step < song_len);

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_song      <= '0;
      r_step      <= '0;
      r_tdiv      <= '0;
      r_step_tick <= 1'b0;
      r_playing   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_song      <= w_song_nxt;
      r_step      <= w_step_nxt;
      r_tdiv      <= w_tdiv_nxt;
      r_step_tick <= w_step_tick_nxt;
      r_playing   <= w_playing_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // next-state and datapath
  always_comb begin
    w_state_nxt = r_state;
    w_song_nxt  = r_song;
    w_step_nxt  = r_step;
    w_tdiv_nxt  = r_tdiv;
    unique case (r_state)
      S_IDLE: begin
        w_song_nxt = sel;
        w_step_nxt = '0;
        w_tdiv_nxt = '0;
        if (play) begin
          w_state_nxt = S_PLAY;
        end
      end
      S_PLAY: begin
        if (w_sel_chg) begin
          w_song_nxt = sel;
          w_step_nxt = '0;
          w_tdiv_nxt = '0;
        end else if (!play) begin
          w_state_nxt = S_PAUSE;
        end else if (w_tick) begin
          w_tdiv_nxt = '0;
          if (w_more) begin
            w_step_nxt = r_step + 1'b1;
          end else if (loop) begin
            w_step_nxt = '0;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_tdiv_nxt = r_tdiv + 1'b1;
        end
      end
      S_PAUSE: begin
        if (w_sel_chg) begin
          w_song_nxt = sel;
          w_step_nxt = '0;
          w_tdiv_nxt = '0;
        end else if (play) begin
          w_state_nxt = S_PLAY;
        end
      end
      S_DONE: begin
        w_tdiv_nxt = '0;
        if (!play) begin
          w_state_nxt = S_IDLE;
          w_song_nxt  = sel;
          w_step_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // output decode; flag values are registered alongside the state
  always_comb begin
    w_playing_nxt   = (w_state_nxt == S_PLAY);
    w_done_nxt      = (w_state_nxt == S_DONE);
    w_step_tick_nxt = 1'b0;
    if (r_state == S_IDLE) begin
      w_step_tick_nxt = play;
    end else if (r_state == S_PLAY) begin
      w_step_tick_nxt = w_sel_chg || (play && w_tick && (w_more || loop));
    end
  end

  assign addr      = {r_song, r_step};
  assign playing   = r_playing;
  assign done      = r_done;
  assign step_tick = r_step_tick;

endmodule

// File: tb/tb_music_addr_gen.sv
// Bench for music_addr_gen: three instances (TEMPO_DIV 1, 3, 4) share one stimulus stream.
// Each instance is compared with a rule-level model every cycle, and directed checks are added on top.
module tb_music_addr_gen;

  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_DONE = 3;

  typedef struct {
    int mode;
    int song;
    int step;
    int elapsed;
    bit tick;
  } mdl_t;

  typedef struct {
    bit rn; int sel; bit play; bit loop; int len;
    int addr; bit pl; bit dn; bit tk;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [0:0] sel;
  logic       play;
  logic       loop;
  logic [6:0] len;
  logic [7:0] addr_o [3];
  logic       pl_o   [3];
  logic       dn_o   [3];
  logic       tk_o   [3];

  int   total = 0;
  int   bad   = 0;
  int   td [3] = '{1, 3, 4};
  mdl_t mdl [3];
  mdl_t nxt [3];
  vec_t vt [$];

  music_addr_gen #(.SONG_BITS(1), .STEP_BITS(7), .TEMPO_DIV(1)) u_t1 (
    .clk(clk), .reset(rst_n), .sel(sel), .play(play), .loop(loop), .song_len(len),
    .addr(addr_o[0]), .playing(pl_o[0]), .done(dn_o[0]), .step_tick(tk_o[0]));
  music_addr_gen #(.SONG_BITS(1), .STEP_BITS(7), .TEMPO_DIV(3)) u_t3 (
    .clk(clk), .reset(rst_n), .sel(sel), .play(play), .loop(loop), .song_len(len),
    .addr(addr_o[1]), .playing(pl_o[1]), .done(dn_o[1]), .step_tick(tk_o[1]));
  music_addr_gen #(.SONG_BITS(1), .STEP_BITS(7), .TEMPO_DIV(4)) u_t4 (
    .clk(clk), .reset(rst_n), .sel(sel), .play(play), .loop(loop), .song_len(len),
    .addr(addr_o[2]), .playing(pl_o[2]), .done(dn_o[2]), .step_tick(tk_o[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock of the player, described by its rules: 'elapsed' counts play cycles since the last step.
  function automatic mdl_t adv(mdl_t m, int t, bit rn, int s, bit p, bit lp, int ln);
    mdl_t n = m;
    n.tick = 1'b0;
    if (!rn) begin
      n.mode = M_IDLE; n.song = 0; n.step = 0; n.elapsed = 0;
      return n;
    end
    case (m.mode)
      M_IDLE: begin
        n.song = s; n.step = 0; n.elapsed = 0;
        if (p) begin n.mode = M_PLAY; n.tick = 1'b1; end
      end
      M_PLAY: begin
        if (s != m.song) begin
          n.song = s; n.step = 0; n.elapsed = 0; n.tick = 1'b1;
        end else if (!p) begin
          n.mode = M_PAUSE;
        end else if (m.elapsed + 1 >= t) begin
          n.elapsed = 0;
          if (m.step < ln) begin n.step = m.step + 1; n.tick = 1'b1; end
          else if (lp) begin n.step = 0; n.tick = 1'b1; end
          else n.mode = M_DONE;
        end else begin
          n.elapsed = m.elapsed + 1;
        end
      end
      M_PAUSE: begin
        if (s != m.song) begin n.song = s; n.step = 0; n.elapsed = 0; end
        else if (p) n.mode = M_PLAY;
      end
      default: begin
        if (!p) begin n.mode = M_IDLE; n.song = s; n.step = 0; end
      end
    endcase
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_cycle();
    for (int k = 0; k < 3; k++)
      nxt[k] = adv(mdl[k], td[k], rst_n, int'(sel), play, loop, int'(len));
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      mdl[k] = nxt[k];
      chk($sformatf("model[T=%0d] {addr,pl,dn,tk}", td[k]),
          {addr_o[k], pl_o[k], dn_o[k], tk_o[k]},
          {8'((mdl[k].song << 7) + mdl[k].step), mdl[k].mode == M_PLAY,
           mdl[k].mode == M_DONE, mdl[k].tick});
    end
  endtask

  task automatic reset2();
    rst_n = 1'b0; play = 1'b0;
    do_cycle();
    do_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) mdl[k] = '{0, 0, 0, 0, 1'b0};
    rst_n = 1'b0; sel = 1'b0; play = 1'b0; loop = 1'b0; len = 7'd0;

    // TEMPO_DIV=1 vectors: reset, looped start, one-shot end, DONE/IDLE, mid-play reset, pause
    vt.push_back('{0,0,0,0,0, 'h00,0,0,0});
    vt.push_back('{0,0,0,0,0, 'h00,0,0,0});
    vt.push_back('{1,1,1,1,3, 'h80,1,0,1});
    vt.push_back('{1,1,1,1,3, 'h81,1,0,1});
    vt.push_back('{1,1,1,1,3, 'h82,1,0,1});
    vt.push_back('{1,1,1,1,3, 'h83,1,0,1});
    vt.push_back('{1,1,1,1,3, 'h80,1,0,1});
    vt.push_back('{1,1,1,1,3, 'h81,1,0,1});
    vt.push_back('{1,1,1,0,5, 'h82,1,0,1});
    vt.push_back('{1,1,1,0,5, 'h83,1,0,1});
    vt.push_back('{1,1,1,0,5, 'h84,1,0,1});
    vt.push_back('{1,1,1,0,5, 'h85,1,0,1});
    vt.push_back('{1,1,1,0,5, 'h85,0,1,0});
    vt.push_back('{1,1,1,0,5, 'h85,0,1,0});
    vt.push_back('{1,0,1,0,5, 'h85,0,1,0});
    vt.push_back('{1,0,0,0,5, 'h00,0,0,0});
    vt.push_back('{1,1,0,0,5, 'h80,0,0,0});
    vt.push_back('{1,1,1,0,5, 'h80,1,0,1});
    vt.push_back('{0,1,1,0,5, 'h00,0,0,0});
    vt.push_back('{1,1,1,0,5, 'h80,1,0,1});
    vt.push_back('{1,1,0,0,5, 'h80,0,0,0});
    vt.push_back('{1,0,0,0,5, 'h00,0,0,0});
    vt.push_back('{1,0,1,0,5, 'h00,1,0,0});
    vt.push_back('{1,0,1,0,5, 'h01,1,0,1});
    vt.push_back('{1,0,0,0,5, 'h01,0,0,0});

    foreach (vt[i]) begin
      rst_n = vt[i].rn; sel = 1'(vt[i].sel); play = vt[i].play;
      loop = vt[i].loop; len = 7'(vt[i].len);
      do_cycle();
      chk($sformatf("vec%0d addr", i), addr_o[0], vt[i].addr);
      chk($sformatf("vec%0d flags", i), {pl_o[0], dn_o[0], tk_o[0]},
          {vt[i].pl, vt[i].dn, vt[i].tk});
    end

    // tempo 4: each step held 4 cycles, sequence 0,1,2,0
    reset2();
    sel = 1'b0; loop = 1'b1; len = 7'd2; play = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      do_cycle();
      chk($sformatf("tempo4 addr c%0d", i), addr_o[2], (i / 4) % 3);
      chk($sformatf("tempo4 tick c%0d", i), tk_o[2], (i % 4) == 0);
    end

    // tempo 3: pause with tdiv=1, and the step lands 2 cycles after resume
    reset2();
    sel = 1'b0; loop = 1'b1; len = 7'd10; play = 1'b1;
    do_cycle();
    do_cycle();
    play = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_cycle();
      chk("pause frozen", {addr_o[1], tk_o[1], pl_o[1]}, {8'h00, 1'b0, 1'b0});
    end
    play = 1'b1;
    do_cycle();
    chk("resume edge", {addr_o[1], tk_o[1], pl_o[1]}, {8'h00, 1'b0, 1'b1});
    do_cycle();
    chk("resume +1", {addr_o[1], tk_o[1]}, {8'h00, 1'b0});
    do_cycle();
    chk("resume +2", {addr_o[1], tk_o[1]}, {8'h01, 1'b1});

    // song switch at step 40, then song_len lowered under the current step
    reset2();
    sel = 1'b0; loop = 1'b1; len = 7'd100; play = 1'b1;
    repeat (41) do_cycle();
    chk("step 40", addr_o[0], 8'd40);
    sel = 1'b1;
    do_cycle();
    chk("switch addr", {addr_o[0], tk_o[0]}, {8'h80, 1'b1});
    do_cycle();
    chk("switch next", addr_o[0], 8'h81);
    repeat (9) do_cycle();
    chk("step 10", addr_o[0], 8'h8A);
    len = 7'd3;
    do_cycle();
    chk("lowered len wrap", {addr_o[0], tk_o[0]}, {8'h80, 1'b1});

    // reset at step 17 with play held high
    reset2();
    sel = 1'b0; loop = 1'b1; len = 7'd100; play = 1'b1;
    repeat (18) do_cycle();
    chk("step 17", addr_o[0], 8'd17);
    rst_n = 1'b0;
    do_cycle();
    chk("mid reset", {addr_o[0], pl_o[0], dn_o[0], tk_o[0]}, 11'h0);
    rst_n = 1'b1;

    // song_len all-ones: one-shot finishes at 127, loop wraps to 0
    reset2();
    sel = 1'b1; loop = 1'b0; len = 7'h7F; play = 1'b1;
    repeat (128) do_cycle();
    chk("max step", {addr_o[0], pl_o[0]}, {8'hFF, 1'b1});
    do_cycle();
    chk("max oneshot done", {addr_o[0], pl_o[0], dn_o[0]}, {8'hFF, 1'b0, 1'b1});
    play = 1'b0;
    do_cycle();
    chk("done to idle", {addr_o[0], dn_o[0]}, {8'h80, 1'b0});
    play = 1'b1; loop = 1'b1;
    repeat (128) do_cycle();
    do_cycle();
    chk("max loop wrap", {addr_o[0], tk_o[0], pl_o[0]}, {8'h80, 1'b1, 1'b1});

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      play  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) sel = ~sel;
      if ($urandom_range(0, 19) == 0) loop = 1'($urandom);
      len = ($urandom_range(0, 29) == 0) ? 7'h7F : 7'($urandom_range(0, 9));
      do_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
